// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester-side and UART-side handshake bundle for uart_tx_arb.
// The arbiter connects through the slave modport. The requesters and the UART
// transmitter (or a testbench standing in for them) connect through the master modport.
interface uart_tx_arb_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: message-granular round-robin arbiter in front of the UART transmitter.
// A requester owns the transmit path from its grant until it completes a byte
// marked last. Bytes pass through combinationally, and the arbiter stores no data.
// Optional feature: define UART_ARB_TIMEOUT_EN to release a grant after TIMEOUT
// consecutive cycles in which the owner offers no byte.
module uart_tx_arb #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arb_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_tx_arb: N_REQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand_idx;

  logic             owner_valid;
  logic             xfer;
  logic             timeout_hit;

  logic             tx_valid_c;
  logic [7:0]       tx_data_c;
  logic [N_REQ-1:0] req_ready_c;

  assign owner_valid = bus.req_valid[owner_q];
  assign xfer        = (state_q == LOCK) && owner_valid && bus.tx_ready;

  // Round-robin pick: the first valid requester at or after last_owner+1, with wraparound.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_owner_q) + k) % N_REQ);
      if (!sel_found && bus.req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Datapath mux: the owner reaches the UART, and everything is held at zero while idle.
  always_comb begin
    tx_valid_c  = 1'b0;
    tx_data_c   = 8'h00;
    req_ready_c = '0;
    if (state_q == LOCK) begin
      tx_valid_c           = owner_valid;
      tx_data_c            = bus.req_data[{owner_q, 3'b000} +: 8];
      req_ready_c[owner_q] = bus.tx_ready;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter: counts owner cycles without a byte and fires on the TIMEOUT-th such cycle.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == LOCK && !owner_valid) begin
      if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: grant on a pick, release on the last transfer or on a timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d          = LOCK;
          owner_d          = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
        end
      end
      LOCK: begin
        if ((xfer && bus.req_last[owner_q]) || timeout_hit) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register. Reset is synchronous and leaves requester 0 first in line.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments, so every flop samples pre-edge values whatever the block order.
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.req_ready = req_ready_c;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == LOCK);

endmodule
